output_quant_pack: RTL and testbench
====================================

Name: output_quant_pack

Overview:
- Sits directly downstream of the activation stage.
- Takes its 32-bit signed valid-qualified results and requantizes each to int8 by multiply, rounding right shift, zero-point add and saturation.
- Packs four int8 results into one 32-bit word and buffers packed words in a small FIFO.
- The FIFO feeds the unified-buffer write path through a valid/ready handshake.
- The upstream stage has no backpressure, so every valid input is accepted unconditionally; FIFO overflow is flagged.

Parameters:
- FIFO_DEPTH, 4, packed-word FIFO entries; power of two, minimum 2.
- SHIFT_W, 5, width of the shift-amount input.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  input sample valid; no ready returned
- data_in  in  32  signed activated value
- scale  in  16  unsigned multiplier
- shift  in  SHIFT_W  right-shift amount, 0..31
- zero_point  in  8  signed output offset
- flush  in  1  single-cycle pulse; emit partially filled word
- out_valid  out  1  FIFO head valid
- out_data  out  32  packed word; first sample in [7:0], fourth in [31:24]
- out_bytes  out  3  valid bytes in out_data, 1..4
- out_ready  in  1  downstream accepts head word
- overflow  out  1  sticky; a packed word was dropped because the FIFO was full
- busy  out  1  pipeline, packer or FIFO non-empty

Behaviour:
- Reset values: all outputs 0; packer byte count 0; FIFO empty; pipeline valids 0; flush_pending 0. Reset mid-operation discards everything in flight.
- Config inputs are sampled in S1 together with data_in. Changing config affects only samples accepted on or after the change.

Pipeline timing:
- S1 (cycle N+1): prod = signed(data_in) * {1'b0, scale}, 49-bit signed.
- S2 (cycle N+2):
  - shift = 0: r = prod.
  - shift > 0: r = (prod + (1 << (shift-1))) >>> shift, i.e. round half toward +inf.
  - v = r + sign-extended zero_point.
  - Saturate v to [-128, 127]; emit byte q.
- Packer (cycle N+3): q is written into lane [cnt] and cnt increments.
  - When the fourth byte lands, the word is pushed to the FIFO with out_bytes = 4 in that same cycle, and cnt returns to 0.
  - Minimum latency, valid_in of the 4th sample to out_valid with an empty FIFO: 3 cycles.

Flush:
- A flush pulse sets flush_pending.
- flush_pending takes effect in the first cycle in which S1, S2 and valid_in are all 0.
- If cnt > 0: push the partial word, unused lanes zero, out_bytes = cnt; cnt cleared.
- If cnt = 0: nothing is pushed.
- flush_pending then clears.
- New valid_in arriving while flush_pending is set delays the flush until those samples have also drained.

FIFO:
- Show-ahead: out_data and out_bytes reflect the head whenever out_valid = 1.
- A word is popped on out_valid && out_ready.
- Push and pop in the same cycle while full: allowed; no overflow.
- Push while full without a simultaneous pop: word dropped, overflow set. overflow stays set until reset.
- out_data and out_bytes are held stable while out_valid && !out_ready.

Other rules:
- busy = S1 valid | S2 valid | cnt != 0 | flush_pending | FIFO non-empty.
- Back-to-back valid_in every cycle is supported; sustained throughput is one word per 4 cycles.

Test Plan:
1. Identity: scale=1, shift=0, zp=0; data 1, 2, 3, 4 on consecutive cycles, out_ready=1 -> out_data=0x04030201, out_bytes=4, out_valid asserted 3 cycles after the 4th valid_in.
2. Saturation and zero point: scale=1, shift=0, zp=-2; data 300, -300, 0, 129 -> out_data=0x7F_FE_80_7F, i.e. bytes 0x7F, 0x80, 0xFE, 0x7F. Note 129-2=127 and -300-2 saturates to 0x80.
3. Rounding: scale=3, shift=2, zp=0; data 5, -5, 2, -2 -> bytes 4, -4, 2, -1 (15+2>>2=4, -15+2>>>2=-4, 6+2>>2=2, -6+2>>>2=-1) -> out_data=0xFF02FC04.
4. Backpressure and overflow: out_ready=0, FIFO_DEPTH=4, 20 consecutive samples of value 1 -> first 4 words held intact and unchanged, 5th word dropped, overflow=1. Then out_ready=1 -> exactly 4 words 0x01010101 popped, busy falls to 0.
5. Flush and simultaneous events:
   - Samples 5, 6, then a flush pulse on the cycle after the second valid_in -> out_data=0x00000605, out_bytes=2.
   - A further flush with cnt=0 -> no word pushed.
   - Push+pop while full -> no overflow.
6. Reset mid-operation: assert rst_n=0 after 2 of 4 samples with 1 word in the FIFO -> out_valid=0, busy=0, overflow=0. Next 4 samples 1..4 -> 0x04030201, with no stale bytes.

Source files
------------

// File: rtl/output_quant_pack.sv
// Requantizes 32-bit activations to int8 (scale, rounding shift, zero point, saturate),
// packs four bytes per word and queues packed words for the unified-buffer write path.
module output_quant_pack #(
  parameter int FIFO_DEPTH = 4,
  parameter int SHIFT_W    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
  input  logic [31:0]        data_in,
  input  logic [15:0]        scale,
  input  logic [SHIFT_W-1:0] shift,
  input  logic [7:0]         zero_point,
  input  logic               flush,
  output logic               out_valid,
  output logic [31:0]        out_data,
  output logic [2:0]         out_bytes,
  input  logic               out_ready,
  output logic               overflow,
  output logic               busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

  // Stage 1: multiply, capture config alongside the product
  logic                     s1_valid;
  logic signed [48:0]       s1_prod;
  logic [SHIFT_W-1:0]       s1_shift;
  logic [7:0]               s1_zp;
  logic signed [48:0]       mul_a;
  logic signed [48:0]       mul_b;

  assign mul_a = {{17{data_in[31]}}, data_in};
  assign mul_b = {33'b0, scale};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_shift <= '0;
      s1_zp    <= '0;
    end else begin
      s1_valid <= valid_in;
      if (valid_in) begin
        s1_prod  <= mul_a * mul_b;
        s1_shift <= shift;
        s1_zp    <= zero_point;
      end
    end
  end

  // Stage 2: round half toward +inf, add zero point, saturate to int8
  logic signed [49:0] prod_x;
  logic        [49:0] rnd;
  logic signed [49:0] rounded;
  logic signed [49:0] with_zp;
  logic        [7:0]  q_next;

  always_comb begin
    prod_x  = {s1_prod[48], s1_prod};
    rnd     = (50'd1 << s1_shift) >> 1;
    rounded = (prod_x + $signed(rnd)) >>> s1_shift;
    with_zp = rounded + {{42{s1_zp[7]}}, s1_zp};
    if (with_zp > 50'sd127)
      q_next = 8'h7f;
    else if (with_zp < -50'sd128)
      q_next = 8'h80;
    else
      q_next = with_zp[7:0];
  end

  logic       s2_valid;
  logic [7:0] s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_q <= q_next;
    end
  end

  // Packer: the lane write and the full-word push share one cycle
  logic [1:0]  cnt;
  logic [31:0] acc;
  logic [31:0] pack_word;
  logic        flush_pending;
  logic        flush_fire;
  logic        pack_push;
  logic        flush_push;
  logic        push;
  logic [31:0] push_data;
  logic [2:0]  push_bytes;

  always_comb begin
    pack_word = acc;
    pack_word[{cnt, 3'b000} +: 8] = s2_q;
  end

  assign pack_push  = s2_valid && (cnt == 2'd3);
  assign flush_fire = flush_pending && !s1_valid && !s2_valid && !valid_in;
  assign flush_push = flush_fire && (cnt != 2'd0);
  assign push       = pack_push || flush_push;
  assign push_data  = pack_push ? pack_word : acc;
  assign push_bytes = pack_push ? 3'd4 : {1'b0, cnt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      acc           <= '0;
      flush_pending <= 1'b0;
    end else begin
      flush_pending <= flush || (flush_pending && !flush_fire);
      if (pack_push || flush_fire) begin
        cnt <= '0;
        acc <= '0;
      end else if (s2_valid) begin
        cnt <= cnt + 2'd1;
        acc <= pack_word;
      end
    end
  end

  // Show-ahead FIFO. Handshake: a word transfers on a cycle with out_valid && out_ready;
  // while out_valid && !out_ready the head (out_data, out_bytes) is held stable.
  logic [34:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          pop;
  logic          do_write;

  assign full     = (count == FULL_CNT);
  assign pop      = out_valid && out_ready;
  assign do_write = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= {push_bytes, push_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      if (do_write && !pop)      count <= count + 1'b1;
      else if (!do_write && pop) count <= count - 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  logic [34:0] head;
  assign head      = mem[rd_ptr];
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? head[31:0]  : 32'd0;
  assign out_bytes = out_valid ? head[34:32] : 3'd0;
  assign busy      = s1_valid || s2_valid || (cnt != 2'd0) || flush_pending || out_valid;

endmodule

// File: tb/tb_output_quant_pack.sv
// Directed bench for output_quant_pack: latency, arithmetic, packing, flush,
// backpressure/overflow and reset, with hand-computed expected words.
module tb_output_quant_pack;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] data_in;
  logic [15:0] scale;
  logic [4:0]  shift;
  logic [7:0]  zero_point;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic        out_ready;
  logic        overflow;
  logic        busy;

  int compared;
  int mismatched;

  output_quant_pack #(.FIFO_DEPTH(4), .SHIFT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .scale      (scale),
    .shift      (shift),
    .zero_point (zero_point),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_bytes  (out_bytes),
    .out_ready  (out_ready),
    .overflow   (overflow),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_sample(input logic [31:0] d);
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = d;
  endtask

  task automatic idle();
    @(negedge clk);
    valid_in = 1'b0;
    data_in  = '0;
  endtask

  task automatic send4(input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] d3);
    push_sample(d0);
    push_sample(d1);
    push_sample(d2);
    push_sample(d3);
    idle();
  endtask

  // Waits (bounded) for a head word, checks it, then steps past the pop edge.
  task automatic wait_word(input string tag, input logic [31:0] exp_data, input logic [2:0] exp_bytes);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_data"}, out_data, exp_data);
    check({tag, "_bytes"}, {29'b0, out_bytes}, {29'b0, exp_bytes});
    @(negedge clk);
  endtask

  task automatic set_cfg(input logic [15:0] sc, input logic [4:0] sh, input logic [7:0] zp);
    scale      = sc;
    shift      = sh;
    zero_point = zp;
  endtask

  initial begin
    int pops;
    logic saw_valid;
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    valid_in   = 1'b0;
    data_in    = '0;
    flush      = 1'b0;
    out_ready  = 1'b0;
    set_cfg(16'd1, 5'd0, 8'd0);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_bytes", {29'b0, out_bytes}, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;

    // 1. Identity with exact 3-cycle latency after the 4th valid_in
    out_ready = 1'b1;
    push_sample(32'd1);
    push_sample(32'd2);
    push_sample(32'd3);
    push_sample(32'd4);
    idle();
    check("t1_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    check("t1_not_yet", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    check("t1_valid", {31'b0, out_valid}, 32'd1);
    check("t1_data", out_data, 32'h04030201);
    check("t1_bytes", {29'b0, out_bytes}, 32'd4);
    @(negedge clk);
    check("t1_popped", {31'b0, out_valid}, 32'd0);

    // 2. Saturation and zero point
    set_cfg(16'd1, 5'd0, 8'hfe);
    send4(32'd300, -32'sd300, 32'd0, 32'd129);
    wait_word("t2", 32'h7ffe807f, 3'd4);

    // 3. Rounding half toward +inf
    set_cfg(16'd3, 5'd2, 8'd0);
    send4(32'd5, -32'sd5, 32'd2, -32'sd2);
    wait_word("t3", 32'hff02fc04, 3'd4);

    // 4. Backpressure and overflow
    set_cfg(16'd1, 5'd0, 8'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) push_sample(32'd1);
    idle();
    repeat (3) @(negedge clk);
    check("t4_head_a", out_data, 32'h01010101);
    check("t4_overflow", {31'b0, overflow}, 32'd1);
    repeat (4) @(negedge clk);
    check("t4_head_b", out_data, 32'h01010101);
    check("t4_bytes", {29'b0, out_bytes}, 32'd4);
    out_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) begin
        pops++;
        check("t4_pop_data", out_data, 32'h01010101);
      end
      @(negedge clk);
    end
    check("t4_pops", pops, 32'd4);
    check("t4_busy", {31'b0, busy}, 32'd0);
    check("t4_sticky", {31'b0, overflow}, 32'd1);

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t4_rst_overflow", {31'b0, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 5a. Partial word flush
    push_sample(32'd5);
    push_sample(32'd6);
    @(negedge clk);
    valid_in = 1'b0;
    flush    = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_word("t5_flush", 32'h00000605, 3'd2);

    // 5b. Flush with an empty packer pushes nothing
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) saw_valid = 1'b1;
      @(negedge clk);
    end
    check("t5_empty_flush", {31'b0, saw_valid}, 32'd0);
    check("t5_empty_busy", {31'b0, busy}, 32'd0);

    // 5c. Push and pop on the same edge while full
    out_ready = 1'b0;
    for (int w = 1; w <= 4; w++)
      for (int b = 0; b < 4; b++) push_sample(w);
    idle();
    repeat (5) @(negedge clk);
    check("t5_full_head", out_data, 32'h01010101);
    push_sample(32'd5);
    push_sample(32'd5);
    push_sample(32'd5);
    push_sample(32'd5);
    idle();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("t5_pp_overflow", {31'b0, overflow}, 32'd0);
    check("t5_pp_head", out_data, 32'h02020202);
    out_ready = 1'b1;
    wait_word("t5_drain2", 32'h02020202, 3'd4);
    wait_word("t5_drain3", 32'h03030303, 3'd4);
    wait_word("t5_drain4", 32'h04040404, 3'd4);
    wait_word("t5_drain5", 32'h05050505, 3'd4);
    check("t5_drained", {31'b0, out_valid}, 32'd0);

    // 6. Reset mid-operation
    out_ready = 1'b0;
    send4(32'd9, 32'd9, 32'd9, 32'd9);
    repeat (3) @(negedge clk);
    check("t6_word_held", out_data, 32'h09090909);
    push_sample(32'd7);
    push_sample(32'd8);
    @(negedge clk);
    valid_in = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("t6_rst_valid", {31'b0, out_valid}, 32'd0);
    check("t6_rst_busy", {31'b0, busy}, 32'd0);
    check("t6_rst_overflow", {31'b0, overflow}, 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send4(32'd1, 32'd2, 32'd3, 32'd4);
    wait_word("t6_clean", 32'h04030201, 3'd4);
    repeat (2) @(negedge clk);
    check("t6_final_busy", {31'b0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
